// File: rtl/wasm_run_ctrl_pkg.sv
// Shared types for the WASM run controller: FSM states, termination codes and core flag bundle.
package wasm_run_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned STATUS_W   = 3;
    localparam int unsigned CNT_W      = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RST  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } run_state_e;

    typedef enum logic [STATUS_W-1:0] {
        STAT_NONE         = 3'd0,
        STAT_OK           = 3'd1,
        STAT_INSTR_ERR    = 3'd2,
        STAT_STACK_EXCEED = 3'd3,
        STAT_EMPTY_POP    = 3'd4,
        STAT_TIMEOUT      = 3'd5,
        STAT_ABORT        = 3'd6
    } run_status_e;

    typedef struct packed {
        logic instr_error;
        logic stack_exceed;
        logic stack_empty_pop;
        logic finish;
    } core_flags_t;

    // Priority encoder for a RUN-cycle termination; STAT_NONE means keep running.
    function automatic run_status_e run_term_code(input logic abort, input core_flags_t f);
        run_status_e code;
        code = STAT_NONE;
        if (abort)                  code = STAT_ABORT;
        else if (f.instr_error)     code = STAT_INSTR_ERR;
        else if (f.stack_exceed)    code = STAT_STACK_EXCEED;
        else if (f.stack_empty_pop) code = STAT_EMPTY_POP;
        else if (f.finish)          code = STAT_OK;
        return code;
    endfunction

endpackage

// File: rtl/wasm_run_ctrl_if.sv
// Host write port and instruction BRAM port of the run controller.
interface wasm_run_ctrl_if
    import wasm_run_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              host_wr_valid;
    logic              host_wr_ready;
    logic [ADDR_W-1:0] host_wr_addr;
    logic [DATA_W-1:0] host_wr_data;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output host_wr_valid, host_wr_addr, host_wr_data,
        input  host_wr_ready, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  host_wr_valid, host_wr_addr, host_wr_data,
        output host_wr_ready, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/wasm_run_ctrl_imem_arb.sv
// Instruction BRAM ownership mux: host writes while it owns the BRAM, core fetches otherwise.
module wasm_run_ctrl_imem_arb
    import wasm_run_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              host_own,
    input  logic              host_wr_valid,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [DATA_W-1:0] host_wr_data,
    input  logic              core_fetch_en,
    input  logic [ADDR_W-1:0] core_fetch_addr,
    output logic              mem_en_c,
    output logic              mem_we_c,
    output logic [ADDR_W-1:0] mem_addr_c,
    output logic [DATA_W-1:0] mem_wdata_c
);

    always_comb begin
        mem_en_c    = core_fetch_en;
        mem_we_c    = 1'b0;
        mem_addr_c  = core_fetch_addr;
        mem_wdata_c = '0;
        if (host_own) begin
            mem_en_c    = host_wr_valid;
            mem_we_c    = host_wr_valid;
            mem_addr_c  = host_wr_addr;
            mem_wdata_c = host_wr_data;
        end
    end

endmodule

// File: rtl/wasm_run_ctrl.sv
// Run controller for the WASM core: loads BRAM from the host, sequences core reset/run,
// and reports a registered termination status and RUN-cycle count.
module wasm_run_ctrl
    import wasm_run_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 500
) (
    input  logic                clk,
    input  logic                rst_n,
    wasm_run_ctrl_if.slave      bus,
    input  logic                host_start,
    input  logic                host_abort,
    output logic                busy,
    output logic                done,
    output logic [STATUS_W-1:0] status,
    output logic [CNT_W-1:0]    cycle_count,
    output logic                core_rst_n,
    input  logic                core_fetch_en,
    input  logic [ADDR_W-1:0]   core_fetch_addr,
    input  logic                core_finish,
    input  logic                core_instr_error,
    input  logic                core_stack_exceed,
    input  logic                core_stack_empty_pop
);

    localparam int unsigned RST_CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    run_state_e           state_q, state_d;
    run_status_e          status_q, status_d;
    logic [CNT_W-1:0]     cycle_count_q, cycle_count_d;
    logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 core_rst_n_q, core_rst_n_d;
    logic                 host_wr_ready_q, host_wr_ready_d;
    core_flags_t          flags;
    run_status_e          term;

    assign flags = '{instr_error:     core_instr_error,
                     stack_exceed:    core_stack_exceed,
                     stack_empty_pop: core_stack_empty_pop,
                     finish:          core_finish};
    assign term  = run_term_code(host_abort, flags);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            status_q        <= STAT_NONE;
            cycle_count_q   <= '0;
            rst_cnt_q       <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            core_rst_n_q    <= 1'b0;
            host_wr_ready_q <= 1'b1;
        end else begin
            state_q         <= state_d;
            status_q        <= status_d;
            cycle_count_q   <= cycle_count_d;
            rst_cnt_q       <= rst_cnt_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            core_rst_n_q    <= core_rst_n_d;
            host_wr_ready_q <= host_wr_ready_d;
        end
    end

    // Next state; outputs are decoded from state_d so they register with the state itself.
    always_comb begin
        state_d       = state_q;
        status_d      = status_q;
        cycle_count_d = cycle_count_q;
        rst_cnt_d     = rst_cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (host_start) begin
                    state_d       = S_RST;
                    status_d      = STAT_NONE;
                    cycle_count_d = '0;
                    rst_cnt_d     = '0;
                end
            end
            S_RST: begin
                if (host_abort) begin
                    state_d  = S_DONE;
                    status_d = STAT_ABORT;
                end else if (rst_cnt_q == RST_CNT_W'(RST_CYCLES - 1)) begin
                    state_d = S_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
                end
            end
            S_RUN: begin
                if (term != STAT_NONE) begin
                    state_d  = S_DONE;
                    status_d = term;
                end else if (cycle_count_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d       = S_DONE;
                    status_d      = STAT_TIMEOUT;
                    cycle_count_d = CNT_W'(TIMEOUT);
                end else begin
                    cycle_count_d = cycle_count_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d          = (state_d == S_RST) || (state_d == S_RUN);
        done_d          = (state_d == S_DONE);
        core_rst_n_d    = (state_d == S_RUN);
        host_wr_ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
    end

    wasm_run_ctrl_imem_arb #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_imem_arb (
        .host_own        (host_wr_ready_q),
        .host_wr_valid   (bus.host_wr_valid),
        .host_wr_addr    (bus.host_wr_addr),
        .host_wr_data    (bus.host_wr_data),
        .core_fetch_en   (core_fetch_en),
        .core_fetch_addr (core_fetch_addr),
        .mem_en_c        (bus.mem_en),
        .mem_we_c        (bus.mem_we),
        .mem_addr_c      (bus.mem_addr),
        .mem_wdata_c     (bus.mem_wdata)
    );

    assign bus.host_wr_ready = host_wr_ready_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign status            = status_q;
    assign cycle_count       = cycle_count_q;
    assign core_rst_n        = core_rst_n_q;

endmodule

// File: tb/tb_wasm_run_ctrl.sv
// Randomized run-scenario bench for wasm_run_ctrl against a per-run expected-outcome model.
module tb_wasm_run_ctrl;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned RST_CYCLES = 2;
    localparam int unsigned TIMEOUT    = 20;

    localparam int K_FLAGS   = 0;
    localparam int K_TIMEOUT = 1;
    localparam int K_RST_AB  = 2;
    localparam int K_RUN_AB  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              host_start, host_abort;
    logic              busy, done, core_rst_n;
    logic [2:0]        status;
    logic [31:0]       cycle_count;
    logic              core_fetch_en;
    logic [ADDR_W-1:0] core_fetch_addr;
    logic              core_finish, core_instr_error, core_stack_exceed, core_stack_empty_pop;

    int n_checks = 0;
    int n_errors = 0;

    wasm_run_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    wasm_run_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .bus                  (bus),
        .host_start           (host_start),
        .host_abort           (host_abort),
        .busy                 (busy),
        .done                 (done),
        .status               (status),
        .cycle_count          (cycle_count),
        .core_rst_n           (core_rst_n),
        .core_fetch_en        (core_fetch_en),
        .core_fetch_addr      (core_fetch_addr),
        .core_finish          (core_finish),
        .core_instr_error     (core_instr_error),
        .core_stack_exceed    (core_stack_exceed),
        .core_stack_empty_pop (core_stack_empty_pop)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Flag vector order: {instr_error, stack_exceed, stack_empty_pop, finish}.
    task automatic drive_flags(input logic [3:0] f);
        core_instr_error     = f[3];
        core_stack_exceed    = f[2];
        core_stack_empty_pop = f[1];
        core_finish          = f[0];
    endtask

    // Termination code a run should report given what was raised in the ending cycle.
    function automatic int exp_code(input bit abort, input logic [3:0] f);
        if (abort) return 6;
        if (f[3])  return 2;
        if (f[2])  return 3;
        if (f[1])  return 4;
        if (f[0])  return 1;
        return 0;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"},  32'(busy), 32'd0);
        check_eq({tag, "_done"},  32'(done), 32'd0);
        check_eq({tag, "_stat"},  32'(status), 32'd0);
        check_eq({tag, "_cnt"},   cycle_count, 32'd0);
        check_eq({tag, "_crst"},  32'(core_rst_n), 32'd0);
        check_eq({tag, "_rdy"},   32'(bus.host_wr_ready), 32'd1);
        check_eq({tag, "_we"},    32'(bus.mem_we), 32'd0);
    endtask

    task automatic host_write_check(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.host_wr_valid = 1'b1;
        bus.host_wr_addr  = a;
        bus.host_wr_data  = d;
        #1;
        check_eq("wr_rdy",   32'(bus.host_wr_ready), 32'd1);
        check_eq("wr_we",    32'(bus.mem_we), 32'd1);
        check_eq("wr_en",    32'(bus.mem_en), 32'd1);
        check_eq("wr_addr",  32'(bus.mem_addr), 32'(a));
        check_eq("wr_wdata", 32'(bus.mem_wdata), 32'(d));
        step();
        bus.host_wr_valid = 1'b0;
    endtask

    // One full run: start, RST phase, RUN phase ending per 'kind' at index k, then DONE checks.
    task automatic run_case(input int kind, input int k, input logic [3:0] f,
                            input bit poke_start, input bit poke_bus, input bit wr_start);
        bit   ended = 0;
        int   e_stat, e_cnt;
        logic [ADDR_W-1:0] fa;

        case (kind)
            K_FLAGS:   begin e_stat = exp_code(0, f); e_cnt = k;       end
            K_TIMEOUT: begin e_stat = 5;              e_cnt = TIMEOUT; end
            K_RST_AB:  begin e_stat = 6;              e_cnt = 0;       end
            default:   begin e_stat = 6;              e_cnt = k;       end
        endcase

        host_start = 1'b1;
        if (wr_start) begin
            bus.host_wr_valid = 1'b1;
            bus.host_wr_addr  = ADDR_W'($urandom);
            bus.host_wr_data  = DATA_W'($urandom);
            #1;
            check_eq("wrst_we", 32'(bus.mem_we), 32'd1);
        end
        step();
        host_start        = 1'b0;
        bus.host_wr_valid = 1'b0;
        if (wr_start) check_eq("wrst_rdy", 32'(bus.host_wr_ready), 32'd0);

        for (int i = 0; i < int'(RST_CYCLES); i++) begin
            if (!ended) begin
                check_eq("rst_low",  32'(core_rst_n), 32'd0);
                check_eq("rst_busy", 32'(busy), 32'd1);
                drive_flags(4'($urandom));
                if (kind == K_RST_AB && i == k) host_abort = 1'b1;
                step();
                host_abort = 1'b0;
                drive_flags(4'b0);
                if (kind == K_RST_AB && i == k) ended = 1;
            end
        end

        if (!ended) check_eq("run_rel", 32'(core_rst_n), 32'd1);
        for (int j = 0; j < int'(TIMEOUT); j++) begin
            if (!ended) begin
                check_eq("run_cnt", cycle_count, 32'(j));
                if (poke_start && j == 0) host_start = 1'b1;
                if (poke_bus && j == 0) begin
                    fa = ADDR_W'($urandom);
                    bus.host_wr_valid = 1'b1;
                    bus.host_wr_addr  = ADDR_W'($urandom);
                    bus.host_wr_data  = DATA_W'($urandom);
                    core_fetch_en     = 1'b1;
                    core_fetch_addr   = fa;
                    #1;
                    check_eq("run_rdy",   32'(bus.host_wr_ready), 32'd0);
                    check_eq("run_we",    32'(bus.mem_we), 32'd0);
                    check_eq("run_en",    32'(bus.mem_en), 32'd1);
                    check_eq("run_addr",  32'(bus.mem_addr), 32'(fa));
                    check_eq("run_wdata", 32'(bus.mem_wdata), 32'd0);
                end
                if ((kind == K_FLAGS || kind == K_RUN_AB) && j == k) begin
                    drive_flags(f);
                    if (kind == K_RUN_AB) host_abort = 1'b1;
                end
                step();
                host_start        = 1'b0;
                host_abort        = 1'b0;
                bus.host_wr_valid = 1'b0;
                core_fetch_en     = 1'b0;
                drive_flags(4'b0);
                if (kind != K_TIMEOUT && j == k) ended = 1;
            end
        end

        check_eq("end_done", 32'(done), 32'd1);
        check_eq("end_busy", 32'(busy), 32'd0);
        check_eq("end_crst", 32'(core_rst_n), 32'd0);
        check_eq("end_rdy",  32'(bus.host_wr_ready), 32'd1);
        check_eq("end_stat", 32'(status), 32'(e_stat));
        check_eq("end_cnt",  cycle_count, 32'(e_cnt));

        // DONE must ignore abort and core flags and hold its results.
        host_abort = 1'b1;
        drive_flags(4'hF);
        step();
        host_abort = 1'b0;
        drive_flags(4'b0);
        check_eq("hold_done", 32'(done), 32'd1);
        check_eq("hold_stat", 32'(status), 32'(e_stat));
        check_eq("hold_cnt",  cycle_count, 32'(e_cnt));
    endtask

    initial begin
        rst_n             = 1'b0;
        host_start        = 1'b0;
        host_abort        = 1'b0;
        bus.host_wr_valid = 1'b0;
        bus.host_wr_addr  = '0;
        bus.host_wr_data  = '0;
        core_fetch_en     = 1'b0;
        core_fetch_addr   = '0;
        drive_flags(4'b0);

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        step();
        check_reset_outputs("idle");

        host_write_check(ADDR_W'(3), DATA_W'(8'h41));

        run_case(K_FLAGS,   7, 4'b0001, 1'b1, 1'b1, 1'b0);
        run_case(K_FLAGS,   3, 4'b1001, 1'b0, 1'b0, 1'b1);
        run_case(K_FLAGS,   0, 4'b0110, 1'b0, 1'b1, 1'b0);
        run_case(K_FLAGS,  int'(TIMEOUT) - 1, 4'b0010, 1'b0, 1'b0, 1'b0);
        run_case(K_TIMEOUT, 0, 4'b0000, 1'b1, 1'b0, 1'b0);
        run_case(K_RST_AB,  0, 4'b0000, 1'b0, 1'b0, 1'b0);
        run_case(K_RST_AB,  int'(RST_CYCLES) - 1, 4'b0000, 1'b0, 1'b0, 1'b0);
        run_case(K_RUN_AB,  5, 4'b1111, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a run.
        host_start = 1'b1;
        step();
        host_start = 1'b0;
        repeat (RST_CYCLES + 3) step();
        check_eq("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        step();
        rst_n = 1'b1;
        step();
        check_reset_outputs("post_rst");
        run_case(K_FLAGS, 4, 4'b0001, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int          kind, k;
            logic [3:0]  f;
            kind = int'($urandom_range(0, 3));
            if (kind == K_RST_AB) k = int'($urandom_range(0, RST_CYCLES - 1));
            else                  k = int'($urandom_range(0, TIMEOUT - 1));
            if (kind == K_FLAGS)  f = 4'($urandom_range(1, 15));
            else                  f = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                step();
                host_write_check(ADDR_W'($urandom), DATA_W'($urandom));
            end
            run_case(kind, k, f, 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wasm_run_ctrl.md
# wasm_run_ctrl

Run controller and instruction-memory arbiter for the WASM core. It gives a host exclusive write access to the instruction BRAM while the core is idle, then holds the core in reset, releases it, and hands the BRAM to the core's fetch port. It watches the core's finish and error flags, applies a watchdog timeout, and reports a registered status code and cycle count. It sits between the host/loader and WASM_TOP's reset, instruction-memory port and status outputs.

## Interface
- ADDR_W, `instr_log2_bram_depth, instruction BRAM address width
- DATA_W, 8, BRAM word width (one bytecode byte)
- RST_CYCLES, 2, cycles core_rst_n is held low before a run (≥1)
- TIMEOUT, 500, maximum RUN cycles before a forced stop (≥1)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- host_wr_valid  in  1  host BRAM write request
- host_wr_ready  out  1  host owns BRAM; write accepted when valid&ready
- host_wr_addr  in  ADDR_W  host write address
- host_wr_data  in  DATA_W  host write data
- host_start  in  1  single-cycle pulse: start a run
- host_abort  in  1  single-cycle pulse: stop the current run
- busy  out  1  state is RST or RUN
- done  out  1  last run terminated; held until next start
- status  out  3  termination code of last run
- cycle_count  out  32  RUN-cycle count of last/current run
- core_rst_n  out  1  active-low reset to core
- core_fetch_en  in  1  core BRAM read enable
- core_fetch_addr  in  ADDR_W  core BRAM read address
- core_finish, core_instr_error, core_stack_exceed, core_stack_empty_pop  in  1 each  core status flags
- mem_en, mem_we  out  1 each  BRAM enable / write enable
- mem_addr  out  ADDR_W  BRAM address
- mem_wdata  out  DATA_W  BRAM write data

## Operation
- States: IDLE, RST, RUN, DONE. Host owns BRAM in IDLE/DONE; core owns it in RST/RUN.
- IDLE/DONE + host_start → RST: status←0, done←0, cycle_count←0, RST counter←0.
- RST: core_rst_n=0. After RST_CYCLES cycles → RUN. host_abort → DONE, status 6.
- RUN: core_rst_n=1. Each edge, in priority order: host_abort → DONE, status 6; instr_error → 2; stack_exceed → 3; stack_empty_pop → 4; finish → 1; none of these and cycle_count==TIMEOUT-1 → DONE, status 5, cycle_count←TIMEOUT; otherwise cycle_count+1. On any termination, cycle_count is frozen (no increment).
- DONE: done=1, core_rst_n=0, status and cycle_count held.
- Status codes: 0 none, 1 ok, 2 instr_error, 3 stack_exceed, 4 empty_pop, 5 timeout, 6 abort.
- BRAM mux (combinational): host-owned → mem_addr=host_wr_addr, mem_wdata=host_wr_data, mem_en=mem_we=host_wr_valid. Core-owned → mem_addr=core_fetch_addr, mem_en=core_fetch_en, mem_we=0, mem_wdata=0.
- host_wr_ready = (state==IDLE || state==DONE).
- Ignored inputs: host_start while busy; host_abort in IDLE/DONE; core flags outside RUN.

## Timing
- Reset values: state IDLE, busy 0, done 0, status 0, cycle_count 0, core_rst_n 0, host_wr_ready 1, mem_we 0.
- Write and start in the same cycle: the write is accepted, and host_wr_ready drops the next cycle.
- Start in cycle t: RST occupies t+1 … t+RST_CYCLES; the first RUN cycle is t+RST_CYCLES+1.
- A flag sampled high in the k-th RUN cycle (k=0 is the first) gives cycle_count=k. done=1 and busy=0 from the next cycle.
- core_rst_n is a registered output, with no glitch at state changes.
- rst_n asserted mid-run: immediate return to IDLE with reset values; BRAM contents are untouched.

## Structure
- State encodings and status codes are `defines in wasm_defines.vh, shared with the top level and the bench.
- Natural sub-module: wasm_imem_arb, the BRAM ownership mux. The FSM, counters and priority encoder stay in wasm_run_ctrl.

## Test plan
- Reset → IDLE, host_wr_ready=1, core_rst_n=0. Write 0x41 to addr 3 → mem_we=1, mem_addr=3, mem_wdata=0x41 in that cycle.
- Start with RST_CYCLES=2, core_finish in RUN cycle 7 → core_rst_n low for exactly 2 cycles, then status=1, cycle_count=7, done=1, busy=0.
- core_finish and core_instr_error high together → status=2. stack_exceed and empty_pop together → status=3.
- TIMEOUT=20, no core flags → DONE after 20 RUN cycles, status=5, cycle_count=20.
- host_abort in the RST phase → status=6. host_start while busy → ignored. Host write attempted during RUN → host_wr_ready=0, mem_we=0, and mem_addr follows core_fetch_addr.
- rst_n pulsed during RUN → all outputs return to their reset values, and a subsequent start runs normally.
